// File: rtl/adc_serial_rx_multi.sv
// Multi-channel serial ADC capture engine: generates adc_sclk/cs_n, shifts one
// sdata line per channel and publishes all channels together on done_tick.
module adc_serial_rx_multi #(
  parameter int CHANNELS   = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          cont,
  input  logic [CHANNELS-1:0]           sdata,
  output logic                          adc_sclk,
  output logic                          cs_n,
  output logic                          busy,
  output logic                          done_tick,
  output logic [CHANNELS*DATA_BITS-1:0] dout
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int Q_W   = $clog2(QUIET_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } state_e;

  state_e                               state_q, state_d;
  logic [DIV_W-1:0]                     div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]                     bit_cnt_q, bit_cnt_d;
  logic [Q_W-1:0]                       q_cnt_q, q_cnt_d;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   sr_q, sr_d, sr_shift;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   dout_q, dout_d;
  logic                                 sclk_q, sclk_d;
  logic                                 cs_n_q, cs_n_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sr_shift[c] = (sr_q[c] << 1) | DATA_BITS'(sdata[c]);
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    q_cnt_d   = q_cnt_q;
    sr_d      = sr_q;
    dout_d    = dout_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (start || cont) begin
          state_d   = SHIFT;
          cs_n_d    = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          // sclk currently low, so this wrap is a rising edge: capture a bit
          if (!sclk_q) begin
            sr_d      = sr_shift;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
              state_d = QUIET;
              cs_n_d  = 1'b1;
              done_d  = 1'b1;
              dout_d  = sr_shift;
              q_cnt_d = '0;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      QUIET: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (q_cnt_q == Q_W'(QUIET_CYC)) begin
          if (cont || start) begin
            state_d   = SHIFT;
            cs_n_d    = 1'b0;
            div_cnt_d = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          q_cnt_d = q_cnt_q + Q_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      q_cnt_q   <= '0;
      sr_q      <= '0;
      dout_q    <= '0;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      q_cnt_q   <= q_cnt_d;
      sr_q      <= sr_d;
      dout_q    <= dout_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign adc_sclk  = sclk_q;
  assign cs_n      = cs_n_q;
  assign busy      = busy_q;
  assign done_tick = done_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// Scoreboard bench for adc_serial_rx_multi (CLK_DIV=2): converter model drives
// sdata on sclk falls, expected dout values are queued and checked on done_tick.
module tb_adc_serial_rx_multi;
  localparam int CH = 2;
  localparam int DB = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic [CH-1:0]     sdata = '0;
  logic              adc_sclk, cs_n, busy, done_tick;
  logic [CH*DB-1:0]  dout;

  adc_serial_rx_multi #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .sdata(sdata),
    .adc_sclk(adc_sclk), .cs_n(cs_n), .busy(busy), .done_tick(done_tick), .dout(dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int idle_viol = 0;

  logic [31:0] frm_q[$];
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: each sclk fall presents the next frame bit, MSB first
  logic        drv_prev = 1'b1;
  int          fcnt = 0;
  logic [31:0] cur = '0;
  always @(negedge clk) begin
    if (cs_n) begin
      fcnt = 0;
    end else if (drv_prev && !adc_sclk) begin
      if (fcnt == 0) cur = (frm_q.size() > 0) ? frm_q.pop_front() : 32'd0;
      if (fcnt < 16) begin
        sdata[0] = cur[15 - fcnt];
        sdata[1] = cur[31 - fcnt];
      end
      fcnt++;
    end
    drv_prev = adc_sclk;
  end

  logic mon_prev = 1'b1;
  always @(negedge clk) begin
    if (!mon_prev && adc_sclk) rise_cnt++;
    mon_prev = adc_sclk;
    if (cs_n && !adc_sclk) idle_viol++;
    if (done_tick) begin
      done_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_done", 32'd1, 32'd0);
      else check_eq("dout", {8'd0, dout}, exp_q.pop_front());
    end
  end

  task automatic push_frame(input logic [15:0] f0, input logic [15:0] f1, input bit expect_done);
    frm_q.push_back({f1, f0});
    if (expect_done) exp_q.push_back({8'd0, f1[11:0], f0[11:0]});
  endtask

  task automatic start_pulse(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      if (done_tick) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  int t0, t1, t2, t3, lows, d0, r0, h;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_cs_n", cs_n, 1'b1);
    check_eq("rst_sclk", adc_sclk, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done_tick, 1'b0);
    check_eq("rst_dout", dout, 32'd0);

    // Single shot
    push_frame(16'h0ABC, 16'h0123, 1'b1);
    r0 = rise_cnt;
    d0 = done_cnt;
    start_pulse(t0);
    check_eq("ss_cs_n1", cs_n, 1'b0);
    check_eq("ss_busy1", busy, 1'b1);
    lows = 0;
    t1 = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_tick) begin
        t1 = cyc;
        break;
      end
      if (!cs_n) lows++;
      @(negedge clk);
    end
    check_eq("ss_latency", t1 - t0, 65);
    check_eq("ss_cs_low_cycles", lows, 64);
    check_eq("ss_cs_n_at_done", cs_n, 1'b1);
    check_eq("ss_dout_now", dout, 32'h123ABC);
    repeat (2) @(negedge clk);
    check_eq("ss_busy67", busy, 1'b1);
    @(negedge clk);
    check_eq("ss_busy68", busy, 1'b0);
    check_eq("ss_rises", rise_cnt - r0, 16);
    check_eq("ss_done_count", done_cnt - d0, 1);

    // Leading-bit discard
    push_frame(16'hF555, 16'hF555, 1'b1);
    start_pulse(t0);
    wait_done(200, t1);
    check_eq("disc_latency", t1 - t0, 65);
    check_eq("disc_dout", dout, 32'h555555);
    repeat (10) @(negedge clk);

    // Ignored starts during a frame
    push_frame(16'h0456, 16'h0789, 1'b1);
    d0 = done_cnt;
    start_pulse(t0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, t1);
    check_eq("ign_latency", t1 - t0, 65);
    repeat (10) @(negedge clk);
    check_eq("ign_busy", busy, 1'b0);
    check_eq("ign_done_count", done_cnt - d0, 1);

    // Reset mid-frame, then a clean frame
    push_frame(16'h0FFF, 16'h0FFF, 1'b0);
    d0 = done_cnt;
    start_pulse(t0);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_cs_n", cs_n, 1'b1);
    check_eq("mrst_sclk", adc_sclk, 1'b1);
    check_eq("mrst_dout", dout, 32'd0);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_done", done_tick, 1'b0);
    repeat (100) @(negedge clk);
    check_eq("mrst_no_done", done_cnt - d0, 0);
    push_frame(16'h0A5A, 16'h0C3C, 1'b1);
    start_pulse(t0);
    wait_done(200, t1);
    check_eq("mrst_new_latency", t1 - t0, 65);
    repeat (10) @(negedge clk);

    // Continuous mode
    push_frame(16'h0FFF, 16'h0FFF, 1'b1);
    push_frame(16'h0000, 16'h0000, 1'b1);
    push_frame(16'h0800, 16'h0800, 1'b1);
    d0 = done_cnt;
    @(negedge clk);
    cont = 1'b1;
    t0 = cyc;
    @(negedge clk);
    wait_done(200, t1);
    check_eq("cont_first_latency", t1 - t0, 65);
    h = 0;
    while (cs_n && h < 20) begin
      h++;
      @(negedge clk);
    end
    check_eq("cont_cs_high_gap", h, 3);
    wait_done(200, t2);
    check_eq("cont_period12", t2 - t1, 67);
    @(negedge clk);
    repeat (20) @(negedge clk);
    cont = 1'b0;
    wait_done(200, t3);
    check_eq("cont_period23", t3 - t2, 67);
    repeat (200) @(negedge clk);
    check_eq("cont_done_count", done_cnt - d0, 3);
    check_eq("cont_busy_end", busy, 1'b0);
    check_eq("exp_queue_empty", exp_q.size(), 0);
    check_eq("sclk_high_when_cs_high", idle_viol, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
